// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite channel bundle (32-bit data, ADDR_WIDTH address) between axil_cmd_master and a register slave.
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a local command/response port.
// Optional watchdog abort is enabled by defining AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axil_cmd_master_if.master     m_axil
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t                state, next_state;
  logic                  aw_done, w_done;
  logic                  accept, aw_hs, w_hs, b_hs, r_hs, abort;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            resp_q;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = m_axil.awvalid && m_axil.awready;
  assign w_hs   = m_axil.wvalid && m_axil.wready;
  assign b_hs   = m_axil.bvalid && m_axil.bready;
  assign r_hs   = m_axil.rvalid && m_axil.rready;

  // Handshake strobes decode straight from the state register, so an async reset drops them at once.
  assign cmd_ready      = (state == IDLE);
  assign m_axil.awvalid = (state == WR) && !aw_done;
  assign m_axil.wvalid  = (state == WR) && !w_done;
  assign m_axil.bready  = (state == WR_B);
  assign m_axil.arvalid = (state == RD_AR);
  assign m_axil.rready  = (state == RD_R);
  assign rsp_valid      = (state == RSP);

  assign m_axil.awaddr = awaddr_q;
  assign m_axil.wdata  = wdata_q;
  assign m_axil.wstrb  = wstrb_q;
  assign m_axil.araddr = araddr_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer;
  logic          busy;
  logic          timeout_q;

  assign busy        = (state == WR) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
  assign abort       = busy && (timer == TW'(TIMEOUT_CYCLES));
  assign rsp_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept)    timer <= '0;
      else if (busy) timer <= timer + 1'b1;
      if (accept)     timeout_q <= 1'b0;
      else if (abort) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign rsp_timeout    = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state takes its default first, so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (cmd_valid) next_state = cmd_write ? WR : RD_AR;
      WR:      if ((aw_done || m_axil.awready) && (w_done || m_axil.wready)) next_state = WR_B;
      WR_B:    if (m_axil.bvalid) next_state = RSP;
      RD_AR:   if (m_axil.arready) next_state = RD_R;
      RD_R:    if (m_axil.rvalid) next_state = RSP;
      RSP:     if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = RSP;
  end

  // AW and W complete independently; each flag retires its valid the cycle after its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (accept) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Write and read address registers are separate so each bus field holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (accept) begin
      if (cmd_write) begin
        awaddr_q <= cmd_addr;
        wdata_q  <= cmd_wdata;
        wstrb_q  <= cmd_wstrb;
      end else begin
        araddr_q <= cmd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      resp_q  <= '0;
    end else if (abort) begin
      rdata_q <= '0;
      resp_q  <= 2'b10;
    end else if (b_hs) begin
      rdata_q <= '0;
      resp_q  <= m_axil.bresp;
    end else if (r_hs) begin
      rdata_q <= m_axil.rdata;
      resp_q  <= m_axil.rresp;
    end
  end

endmodule
